// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_NREGS_DEF = 32;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  typedef logic [$clog2(RF_NREGS_DEF)-1:0] rf_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: flush beats set, set beats clear; entry 0 never busy.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter  int NREGS = RF_NREGS_DEF,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_set_valid,
  input  logic [AW-1:0]           i_set_idx,
  input  logic [NWR-1:0]          i_clr_en,
  input  logic [NWR-1:0][AW-1:0]  i_clr_sel,
  input  logic                    i_flush,
  output logic [NREGS-1:0]        o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 0; k < NWR; k++) begin
      if (i_clr_en[k]) w_busy_nxt[i_clr_sel[k]] = 1'b0;
    end
    // A new producer issued on the same edge as an older writeback keeps the entry busy.
    if (i_set_valid && (i_set_idx != '0)) w_busy_nxt[i_set_idx] = 1'b1;
    if (i_flush) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (i_en) begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with post-reset zeroing sweep and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp_sb import regfile_pkg::*; #(
  parameter  int XLEN  = RF_XLEN_DEF,
  parameter  int NREGS = RF_NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      ready,
  input  logic [NRD-1:0][AW-1:0]    rd_sel,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR-1:0][AW-1:0]    wr_sel,
  input  logic [NWR-1:0][XLEN-1:0]  wr_data,
  input  logic                      iss_valid,
  input  logic [AW-1:0]             iss_rd,
  input  logic                      sb_flush,
  output rf_state_e                 o_dbg_state
);

  rf_state_e        r_state;
  logic [AW-1:0]    r_sweep_cnt;
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;
  logic             w_run;

  assign w_run       = (r_state == RF_RUN);
  assign ready       = w_run;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RF_INIT;
      r_sweep_cnt <= '0;
    end else if (r_state == RF_INIT) begin
      r_sweep_cnt <= r_sweep_cnt + 1'b1;
      if (r_sweep_cnt == AW'(NREGS - 1)) r_state <= RF_RUN;
    end
  end

  // Storage has no reset so it can map onto distributed RAM; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (r_state == RF_INIT) begin
      r_regs[r_sweep_cnt] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && (wr_sel[k] != '0)) r_regs[wr_sel[k]] <= wr_data[k];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_run),
    .i_set_valid (iss_valid),
    .i_set_idx   (iss_rd),
    .i_clr_en    (wr_en),
    .i_clr_sel   (wr_sel),
    .i_flush     (sb_flush),
    .o_busy      (w_busy)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (w_run && (rd_sel[p] != '0)) begin
        rd_data[p] = r_regs[rd_sel[p]];
        rd_busy[p] = w_busy[rd_sel[p]];
`ifdef REGFILE_BYPASS_EN
        // Higher-numbered write port is scanned last so it wins the forward.
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && (wr_sel[k] == rd_sel[p])) begin
            rd_data[p] = wr_data[k];
            rd_busy[p] = 1'b0;
          end
        end
`else
        // Without bypass the caller forwards WB results into ID itself.
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (2 read ports, 2 write ports).
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             ready;
  logic [1:0][4:0]  rd_sel;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_busy;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_sel;
  logic [1:0][31:0] wr_data;
  logic             iss_valid;
  logic [4:0]       iss_rd;
  logic             sb_flush;
  rf_state_e        dbg_state;

  int checks = 0;
  int errors = 0;
  int n;
  logic byp;

  regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ready       (ready),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .sb_flush    (sb_flush),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en     = '0;
    iss_valid = 1'b0;
    sb_flush  = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
`ifdef REGFILE_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rst_n = 1'b0; rd_sel = '0; wr_sel = '0; wr_data = '0; iss_rd = '0;
    idle();
    repeat (3) @(negedge clk);
    rd_sel[0] = 5'd5;
    #1;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(RF_INIT));
    chk("reset_rd_data", rd_data[0], 32'd0);
    chk("reset_rd_busy", 32'(rd_busy), 32'd0);

    // Release reset with traffic that the sweep must ignore
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 2'b01; wr_sel[0] = 5'd5; wr_data[0] = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_rd = 5'd4;
    rd_sel[1] = 5'd4;
    #1;
    chk("init_rd_data", rd_data[0], 32'd0);
    wait_ready(n);
    idle();
    #1;
    chk("sweep_len", 32'(n), 32'd32);
    chk("run_state", 32'(dbg_state), 32'(RF_RUN));
    chk("init_wr_ignored", rd_data[0], 32'd0);
    chk("init_iss_ignored", 32'(rd_busy[1]), 32'd0);
    for (int i = 1; i < 32; i++) begin
      rd_sel[0] = 5'(i);
      #1;
      chk($sformatf("swept_x%0d", i), rd_data[0], 32'd0);
    end

    // Write x5 and read it back
    @(negedge clk);
    wr_en = 2'b01; wr_sel[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF; rd_sel[0] = 5'd5;
    #1;
    chk("x5_same_cycle", rd_data[0], byp ? 32'hDEAD_BEEF : 32'd0);
    @(negedge clk); idle(); #1;
    chk("x5_read", rd_data[0], 32'hDEAD_BEEF);

    // x0 is hardwired zero
    @(negedge clk);
    wr_en = 2'b01; wr_sel[0] = 5'd0; wr_data[0] = 32'h0000_1234; rd_sel[1] = 5'd0;
    @(negedge clk); idle(); #1;
    chk("x0_data", rd_data[1], 32'd0);
    chk("x0_busy", 32'(rd_busy[1]), 32'd0);

    // Both write ports to x6: port 1 wins
    @(negedge clk);
    wr_en = 2'b11; wr_sel[0] = 5'd6; wr_sel[1] = 5'd6;
    wr_data[0] = 32'h1111_1111; wr_data[1] = 32'h2222_2222;
    @(negedge clk); idle(); rd_sel[0] = 5'd6; #1;
    chk("x6_port1_wins", rd_data[0], 32'h2222_2222);

    // Scoreboard set / clear on x7
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7; rd_sel[1] = 5'd7;
    #1;
    chk("x7_busy_no_bypass", 32'(rd_busy[1]), 32'd0);
    @(negedge clk); idle(); #1;
    chk("x7_busy_set", 32'(rd_busy[1]), 32'd1);
    @(negedge clk);
    wr_en = 2'b01; wr_sel[0] = 5'd7; wr_data[0] = 32'h0000_0077;
    #1;
    chk("x7_busy_wr_cycle", 32'(rd_busy[1]), byp ? 32'd0 : 32'd1);
    @(negedge clk); idle(); #1;
    chk("x7_busy_cleared", 32'(rd_busy[1]), 32'd0);
    chk("x7_data", rd_data[1], 32'h0000_0077);
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7;
    @(negedge clk); idle(); #1;
    chk("x7_busy_reset", 32'(rd_busy[1]), 32'd1);
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7;
    wr_en = 2'b01; wr_sel[0] = 5'd7; wr_data[0] = 32'h0000_0078;
    @(negedge clk); idle(); #1;
    chk("x7_set_wins", 32'(rd_busy[1]), 32'd1);
    @(negedge clk);
    wr_en = 2'b10; wr_sel[1] = 5'd7; wr_data[1] = 32'h0000_0079;
    @(negedge clk); idle(); #1;
    chk("x7_clr_port1", 32'(rd_busy[1]), 32'd0);
    chk("x7_data_port1", rd_data[1], 32'h0000_0079);

    // Flush overrides a same-edge set
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd8;
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd3;
    @(negedge clk); idle(); rd_sel[0] = 5'd8; rd_sel[1] = 5'd3; #1;
    chk("x8_busy", 32'(rd_busy[0]), 32'd1);
    chk("x3_busy", 32'(rd_busy[1]), 32'd1);
    @(negedge clk);
    sb_flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd3;
    @(negedge clk); idle(); #1;
    chk("flush_x8", 32'(rd_busy[0]), 32'd0);
    chk("flush_x3", 32'(rd_busy[1]), 32'd0);

    // Issue to x0 never marks busy
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd0; rd_sel[1] = 5'd0;
    @(negedge clk); idle(); #1;
    chk("x0_iss_busy", 32'(rd_busy[1]), 32'd0);

    // Same-cycle write to x9 with busy entry
    @(negedge clk);
    wr_en = 2'b01; wr_sel[0] = 5'd9; wr_data[0] = 32'h0000_0011;
    iss_valid = 1'b1; iss_rd = 5'd9;
    @(negedge clk); idle(); rd_sel[0] = 5'd9; #1;
    chk("x9_old_data", rd_data[0], 32'h0000_0011);
    chk("x9_old_busy", 32'(rd_busy[0]), 32'd1);
    @(negedge clk);
    wr_en = 2'b01; wr_sel[0] = 5'd9; wr_data[0] = 32'hA5A5_A5A5;
    #1;
    chk("x9_bypass_data", rd_data[0], byp ? 32'hA5A5_A5A5 : 32'h0000_0011);
    chk("x9_bypass_busy", 32'(rd_busy[0]), byp ? 32'd0 : 32'd1);
    @(negedge clk); idle(); #1;
    chk("x9_new_data", rd_data[0], 32'hA5A5_A5A5);
    chk("x9_new_busy", 32'(rd_busy[0]), 32'd0);

    // Reset in RUN, then again mid-sweep at cycle 10
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rerst_ready", 32'(ready), 32'd0);
    chk("rerst_rd_data", rd_data[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_sweep_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_sweep_state", 32'(dbg_state), 32'(RF_INIT));
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("restart_sweep_len", 32'(n), 32'd32);
    rd_sel[0] = 5'd5;
    #1;
    chk("restart_x5_zero", rd_data[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
